// File: rtl/mem_arb_pkg.sv
// Shared definitions for the IF/MEM single-port memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DATA  = 2'd2
    } arb_state_t;

    localparam int DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/mem_watchdog.sv
// Counts stalled memory-request cycles; raises a sticky error at TIMEOUT.
module mem_watchdog
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic reset,
    input  logic active,
    input  logic done,
    output logic err
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] r_cnt;
    logic          r_err;

    // Counter saturates at TIMEOUT so a long hang cannot wrap it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else if (done) begin
            r_cnt <= '0;
        end else if (active && (r_cnt != CW'(TIMEOUT))) begin
            r_cnt <= r_cnt + CW'(1);
            if (r_cnt == CW'(TIMEOUT - 1))
                r_err <= 1'b1;
        end
    end

    assign err = r_err;

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one single-ported memory between the IF and MEM pipeline stages,
// one transaction outstanding at a time, data accesses first.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    output logic              if_stall,
    input  logic              dm_read,
    input  logic              dm_write,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_valid,
    output logic              dm_stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              bus_err
);

    arb_state_t        r_state;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_dm_rdata;
    logic              r_if_valid;
    logic              r_dm_valid;
    logic              r_drop;

    logic w_done;
    logic w_dreq;

    assign w_done = r_mem_req & mem_ready;
    assign w_dreq = dm_read | dm_write;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_rdata  <= '0;
            r_dm_rdata  <= '0;
            r_if_valid  <= 1'b0;
            r_dm_valid  <= 1'b0;
            r_drop      <= 1'b0;
        end else begin
            r_if_valid <= 1'b0;
            r_dm_valid <= 1'b0;
            case (r_state)
                // No arbitration while a valid pulse is out: the requester
                // needs that cycle to present its next request.
                ST_IDLE: begin
                    if (!r_if_valid && !r_dm_valid) begin
                        if (w_dreq) begin
                            r_state     <= ST_DATA;
                            r_mem_req   <= 1'b1;
                            r_mem_we    <= dm_write;
                            r_mem_addr  <= dm_addr;
                            r_mem_wdata <= dm_wdata;
                        end else if (if_req) begin
                            r_state    <= ST_FETCH;
                            r_mem_req  <= 1'b1;
                            r_mem_we   <= 1'b0;
                            r_mem_addr <= if_addr;
                            r_drop     <= 1'b0;
                        end
                    end
                end
                ST_FETCH: begin
                    if (if_flush)
                        r_drop <= 1'b1;
                    if (w_done) begin
                        r_state   <= ST_IDLE;
                        r_mem_req <= 1'b0;
                        r_drop    <= 1'b0;
                        if (!(r_drop || if_flush)) begin
                            r_if_rdata <= mem_rdata;
                            r_if_valid <= 1'b1;
                        end
                    end
                end
                ST_DATA: begin
                    if (w_done) begin
                        r_state    <= ST_IDLE;
                        r_mem_req  <= 1'b0;
                        r_mem_we   <= 1'b0;
                        r_dm_rdata <= mem_rdata;
                        r_dm_valid <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    mem_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_watchdog (
        .clk   (clk),
        .reset (reset),
        .active(r_mem_req & ~mem_ready),
        .done  (w_done),
        .err   (bus_err)
    );

    // A flush in the pulse cycle still kills the fetched instruction.
    assign if_valid  = r_if_valid & ~if_flush;
    assign dm_valid  = r_dm_valid;
    assign if_stall  = if_req & ~if_valid;
    assign dm_stall  = w_dreq & ~dm_valid;
    assign if_rdata  = r_if_rdata;
    assign dm_rdata  = r_dm_rdata;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: transaction-level model checked every cycle
// plus hand-computed expectations for each scenario.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_req, if_flush, dm_read, dm_write, mem_ready;
    logic [AW-1:0] if_addr, dm_addr;
    logic [DW-1:0] dm_wdata, mem_rdata;
    logic [DW-1:0] if_rdata, dm_rdata, mem_wdata;
    logic [AW-1:0] mem_addr;
    logic          if_valid, if_stall, dm_valid, dm_stall, mem_req, mem_we, bus_err;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_rdata(if_rdata), .if_valid(if_valid), .if_stall(if_stall),
        .dm_read(dm_read), .dm_write(dm_write), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_valid(dm_valid), .dm_stall(dm_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: who owns the memory port, what it asked for, and pending pulses.
    bit          m_known = 0;
    int          m_owner;          // 0 none, 1 fetch, 2 data
    logic [31:0] m_addr, m_wdata, m_ifr, m_dmr;
    bit          m_we, m_ifv, m_dmv, m_drop, m_err;
    int          m_wait;
    bit          p_ifv, p_dmv, e_ifv;

    always @(negedge clk) begin
        if (m_known) begin
            e_ifv = m_ifv && !if_flush;
            check("mem_req", mem_req, m_owner != 0);
            check("mem_we", mem_we, (m_owner == 2) && m_we);
            if (m_owner != 0) check("mem_addr", mem_addr, m_addr);
            if (m_owner == 2 && m_we) check("mem_wdata", mem_wdata, m_wdata);
            check("if_valid", if_valid, e_ifv);
            check("dm_valid", dm_valid, m_dmv);
            check("if_stall", if_stall, if_req && !e_ifv);
            check("dm_stall", dm_stall, (dm_read || dm_write) && !m_dmv);
            check("bus_err", bus_err, m_err);
            if (e_ifv) check("if_rdata", if_rdata, m_ifr);
            if (m_dmv) check("dm_rdata", dm_rdata, m_dmr);
        end
        if (reset) begin
            m_known = 1; m_owner = 0; m_addr = 0; m_wdata = 0; m_ifr = 0; m_dmr = 0;
            m_we = 0; m_ifv = 0; m_dmv = 0; m_drop = 0; m_err = 0; m_wait = 0;
        end else if (m_known) begin
            p_ifv = m_ifv; p_dmv = m_dmv; m_ifv = 0; m_dmv = 0;
            if (m_owner != 0) begin
                if (mem_ready) begin
                    if (m_owner == 1) begin
                        if (!m_drop && !if_flush) begin m_ifv = 1; m_ifr = mem_rdata; end
                    end else begin
                        m_dmv = 1; m_dmr = mem_rdata;
                    end
                    m_owner = 0; m_drop = 0; m_we = 0; m_wait = 0;
                end else begin
                    if (m_owner == 1 && if_flush) m_drop = 1;
                    m_wait++;
                    if (m_wait >= TO) m_err = 1;
                end
            end else if (!p_ifv && !p_dmv) begin
                if (dm_read || dm_write) begin
                    m_owner = 2; m_we = dm_write; m_addr = dm_addr; m_wdata = dm_wdata;
                end else if (if_req) begin
                    m_owner = 1; m_we = 0; m_addr = if_addr;
                end
            end
        end
    end

    task automatic nxt;
        @(posedge clk);
        #1;
    endtask

    int cnt_a, cnt_b;

    initial begin
        reset = 1; if_req = 0; if_addr = 0; if_flush = 0; dm_read = 0; dm_write = 0;
        dm_addr = 0; dm_wdata = 0; mem_ready = 0; mem_rdata = 0;
        repeat (3) nxt();
        reset = 0;
        @(negedge clk);
        check("rst mem_req", mem_req, 0);
        check("rst mem_we", mem_we, 0);
        check("rst valids", {if_valid, dm_valid}, 0);
        check("rst bus_err", bus_err, 0);
        check("rst mem_addr", mem_addr, 0);
        check("rst mem_wdata", mem_wdata, 0);
        check("rst rdata", if_rdata | dm_rdata, 0);

        // Minimum-latency fetch
        nxt(); if_req = 1; if_addr = 32'h0040_0000;
        nxt(); mem_ready = 1; mem_rdata = 32'h2002_0014;
        @(negedge clk);
        check("s1 mem_req", mem_req, 1);
        check("s1 mem_addr", mem_addr, 32'h0040_0000);
        nxt(); mem_ready = 0;
        @(negedge clk);
        check("s1 if_valid", if_valid, 1);
        check("s1 if_rdata", if_rdata, 32'h2002_0014);
        check("s1 if_stall", if_stall, 0);
        nxt(); if_req = 0;

        // Data beats fetch, fetch follows after dm_valid
        nxt(); if_req = 1; if_addr = 32'h0040_0004; dm_read = 1; dm_addr = 32'h1000_0008;
        nxt(); mem_ready = 1; mem_rdata = 32'hCAFE_0001;
        @(negedge clk);
        check("s2 first addr", mem_addr, 32'h1000_0008);
        nxt(); mem_ready = 0;
        @(negedge clk);
        check("s2 dm_valid", dm_valid, 1);
        check("s2 dm_rdata", dm_rdata, 32'hCAFE_0001);
        check("s2 if_stall", if_stall, 1);
        nxt(); dm_read = 0;
        nxt(); mem_ready = 1; mem_rdata = 32'h0000_0013;
        @(negedge clk);
        check("s2 second addr", mem_addr, 32'h0040_0004);
        nxt(); mem_ready = 0;
        @(negedge clk);
        check("s2 if_valid", if_valid, 1);
        nxt(); if_req = 0;

        // Store with four-cycle memory latency
        nxt(); dm_write = 1; dm_addr = 32'h1000_0010; dm_wdata = 32'hDEAD_BEEF;
        cnt_a = 0; cnt_b = 0;
        for (int i = 1; i <= 6; i++) begin
            nxt();
            mem_ready = (i == 4);
            mem_rdata = 32'h0;
            if (i == 6) dm_write = 0;
            @(negedge clk);
            cnt_a += int'(mem_we);
            cnt_b += int'(dm_valid);
            if (i == 2) check("s3 wdata", mem_wdata, 32'hDEAD_BEEF);
        end
        check("s3 we cycles", cnt_a, 4);
        check("s3 dm_valid pulses", cnt_b, 1);

        // Flush during fetch drops the result, next fetch is normal
        nxt(); if_req = 1; if_addr = 32'h0040_0008;
        cnt_a = 0;
        for (int i = 1; i <= 6; i++) begin
            nxt();
            if_flush = (i == 1);
            if (i == 2) if_addr = 32'h0040_0100;
            mem_ready = (i == 3 || i == 5);
            mem_rdata = (i == 3) ? 32'hBAD0_0BAD : 32'h0000_0093;
            @(negedge clk);
            if (i <= 5) cnt_a += int'(if_valid);
            if (i == 4) check("s4 idle", mem_req, 0);
            if (i == 5) check("s4 refetch addr", mem_addr, 32'h0040_0100);
            if (i == 6) begin
                check("s4 if_valid", if_valid, 1);
                check("s4 if_rdata", if_rdata, 32'h0000_0093);
            end
        end
        check("s4 dropped pulses", cnt_a, 0);
        nxt(); if_req = 0; mem_ready = 0;

        // Timeout: bus_err after TO stalled cycles, sticky past completion
        nxt(); dm_read = 1; dm_addr = 32'h1000_0020;
        for (int i = 1; i <= 13; i++) begin
            nxt();
            mem_ready = (i == 11);
            mem_rdata = 32'h55AA_55AA;
            if (i == 13) dm_read = 0;
            @(negedge clk);
            if (i == 8) check("s5 err early", bus_err, 0);
            if (i == 9) check("s5 err set", bus_err, 1);
            if (i == 12) check("s5 dm_valid", dm_valid, 1);
            if (i == 13) check("s5 err sticky", bus_err, 1);
        end

        // Reset in the second DATA cycle abandons the access
        nxt(); dm_read = 1; dm_addr = 32'h1000_0030;
        nxt();
        nxt(); reset = 1;
        @(negedge clk);
        check("s6 before rst", mem_req, 1);
        nxt(); reset = 0; mem_ready = 1; dm_read = 0; mem_rdata = 32'h1234_5678;
        @(negedge clk);
        check("s6 mem_req", mem_req, 0);
        check("s6 dm_valid", dm_valid, 0);
        check("s6 bus_err", bus_err, 0);
        nxt(); mem_ready = 0;
        @(negedge clk);
        check("s6 late ready", dm_valid, 0);
        check("s6 still idle", mem_req, 0);

        repeat (3) nxt();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
